// File: rtl/fpu_pack.sv
// fpu_pack: packs an unpacked floating-point result into IEEE-754 binary
// interchange format through a 3-stage valid/ready pipeline
// (normalize -> round -> pack).
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  input handshake
//   in_sign            result sign
//   in_exponent        signed biased exponent (E+2 bits)
//   in_significand     {ovf, int, frac[S], G, R, Sticky}
//   in_is_nan/in_is_inf  special-case overrides
//   in_rm              rounding mode (0 RNE, 1 RTZ, 2 RDN, 3 RUP, else RNE)
//   out_valid/out_ready  output handshake
//   out_data           packed {sign, exponent, fraction}
//   out_overflow/out_underflow/out_inexact  exception flags for the beat
module fpu_pack #(
  parameter int EXPONENT_WIDTH    = 11,
  parameter int SIGNIFICAND_WIDTH = 52
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic                                      in_sign,
  input  logic [EXPONENT_WIDTH+1:0]                 in_exponent,
  input  logic [SIGNIFICAND_WIDTH+4:0]              in_significand,
  input  logic                                      in_is_nan,
  input  logic                                      in_is_inf,
  input  logic [2:0]                                in_rm,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [EXPONENT_WIDTH+SIGNIFICAND_WIDTH:0] out_data,
  output logic                                      out_overflow,
  output logic                                      out_underflow,
  output logic                                      out_inexact
);
  localparam int E  = EXPONENT_WIDTH;
  localparam int S  = SIGNIFICAND_WIDTH;
  localparam int W  = S + 5;
  localparam int P  = 1 + E + S;
  localparam int XW = E + 4;  // headroom for +1 carries and wide right shifts

  localparam logic signed [XW-1:0] ONE     = XW'(1);
  localparam logic signed [XW-1:0] W_S     = XW'(W);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << E) - 1);

  // Leading zeros above and including the int bit (ovf bit excluded).
  function automatic logic [XW-1:0] lzc(input logic [W-2:0] v);
    logic [XW-1:0] n;
    n = XW'(W - 1);
    for (int i = 0; i <= W - 2; i++)
      if (v[i]) n = XW'(W - 2 - i);
    return n;
  endfunction

  function automatic logic round_up(input logic [2:0] rm, input logic sign,
                                    input logic lsb, input logic g, input logic rs);
    case (rm)
      3'd1:    return 1'b0;
      3'd2:    return sign & (g | rs);
      3'd3:    return ~sign & (g | rs);
      default: return g & (rs | lsb);
    endcase
  endfunction

  // Overflow saturates to max finite when the mode rounds toward zero for this sign.
  function automatic logic ovf_to_inf(input logic [2:0] rm, input logic sign);
    case (rm)
      3'd1:    return 1'b0;
      3'd2:    return sign;
      3'd3:    return ~sign;
      default: return 1'b1;
    endcase
  endfunction

  logic en1, en2, en3;
  logic vld_p1_q, vld_p2_q, vld_p3_q;

  logic [W-1:0]           sig_n;
  logic signed [XW-1:0]   exp_n;
  logic [XW-1:0]          lz_n, shl_n, shr_n;
  logic                   lost_n;
  logic [W-2:0]           sig_p1_d, sig_p1_q;
  logic signed [XW-1:0]   exp_p1_d, exp_p1_q;
  logic                   tiny_p1_d, tiny_p1_q;
  logic                   sign_p1_q, nan_p1_q, inf_p1_q;
  logic [2:0]             rm_p1_q;

  logic                   inc_p2;
  logic [S+1:0]           sum_p2;
  logic signed [XW-1:0]   exp_p2_d, exp_p2_q;
  logic [S-1:0]           frac_p2_d, frac_p2_q;
  logic                   inx_p2_d, inx_p2_q;
  logic                   sign_p2_q, tiny_p2_q, nan_p2_q, inf_p2_q;
  logic [2:0]             rm_p2_q;

  logic [P-1:0]           data_p3_d, data_p3_q;
  logic                   ovf_p3_d, ovf_p3_q, unf_p3_d, unf_p3_q, inx_p3_d, inx_p3_q;

  assign en3      = out_ready | ~vld_p3_q;
  assign en2      = ~vld_p2_q | en3;
  assign en1      = ~vld_p1_q | en2;
  assign in_ready = ~rst & en1;

  // ---- stage 1: normalize ----
  // A nonzero result whose int bit is still clear ends up encoded with exp=0:
  // the subnormal exponent equals that of exp=1, so the value is unchanged.
  always_comb begin
    sig_n  = in_significand;
    exp_n  = {{2{in_exponent[E+1]}}, in_exponent};
    lz_n   = lzc(in_significand[W-2:0]);
    shl_n  = '0;
    shr_n  = '0;
    lost_n = 1'b0;
    if (sig_n[W-1]) begin
      sig_n = {1'b0, sig_n[W-1:2], sig_n[1] | sig_n[0]};
      exp_n = exp_n + ONE;
    end else if (sig_n == '0) begin
      exp_n = '0;
    end else if (exp_n > ONE) begin
      shl_n = (exp_n - ONE < $signed(lz_n)) ? exp_n - ONE : lz_n;
      sig_n = sig_n << shl_n;
      exp_n = exp_n - $signed(shl_n);
    end
    if (sig_n != '0) begin
      if (exp_n < ONE) begin
        shr_n    = (ONE - exp_n >= W_S) ? W_S : ONE - exp_n;
        lost_n   = |(sig_n << (W_S - shr_n));
        sig_n    = sig_n >> shr_n;
        sig_n[0] = sig_n[0] | lost_n;
        exp_n    = '0;
      end else if (!sig_n[W-2]) begin
        exp_n = '0;
      end
    end
    sig_p1_d  = sig_n[W-2:0];
    exp_p1_d  = exp_n;
    tiny_p1_d = (exp_n == '0);
  end

  // ---- stage 2: round ----
  always_comb begin
    inc_p2    = round_up(rm_p1_q, sign_p1_q, sig_p1_q[3], sig_p1_q[2],
                         sig_p1_q[1] | sig_p1_q[0]);
    sum_p2    = {1'b0, sig_p1_q[S+3:3]} + {{(S+1){1'b0}}, inc_p2};
    exp_p2_d  = exp_p1_q;
    frac_p2_d = sum_p2[S-1:0];
    if (sum_p2[S+1]) begin
      frac_p2_d = sum_p2[S:1];
      exp_p2_d  = exp_p1_q + ONE;
    end else if (exp_p1_q == '0 && sum_p2[S]) begin
      exp_p2_d = ONE;
    end
    inx_p2_d = |sig_p1_q[2:0];
  end

  // ---- stage 3: pack and exceptions ----
  always_comb begin
    data_p3_d = {sign_p2_q, exp_p2_q[E-1:0], frac_p2_q};
    ovf_p3_d  = 1'b0;
    unf_p3_d  = tiny_p2_q & inx_p2_q;
    inx_p3_d  = inx_p2_q;
    if (nan_p2_q) begin
      data_p3_d = {1'b0, {E{1'b1}}, 1'b1, {(S-1){1'b0}}};
      unf_p3_d  = 1'b0;
      inx_p3_d  = 1'b0;
    end else if (inf_p2_q) begin
      data_p3_d = {sign_p2_q, {E{1'b1}}, {S{1'b0}}};
      unf_p3_d  = 1'b0;
      inx_p3_d  = 1'b0;
    end else if (exp_p2_q >= EXP_MAX) begin
      ovf_p3_d  = 1'b1;
      inx_p3_d  = 1'b1;
      unf_p3_d  = 1'b0;
      data_p3_d = ovf_to_inf(rm_p2_q, sign_p2_q) ? {sign_p2_q, {E{1'b1}}, {S{1'b0}}}
                                                 : {sign_p2_q, {(E-1){1'b1}}, 1'b0, {S{1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      if (en1) vld_p1_q <= in_valid;
      if (en2) vld_p2_q <= vld_p1_q;
      if (en3) vld_p3_q <= vld_p2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (en1 && in_valid) begin
      sig_p1_q  <= sig_p1_d;
      exp_p1_q  <= exp_p1_d;
      tiny_p1_q <= tiny_p1_d;
      sign_p1_q <= in_sign;
      nan_p1_q  <= in_is_nan;
      inf_p1_q  <= in_is_inf;
      rm_p1_q   <= in_rm;
    end
    if (en2 && vld_p1_q) begin
      exp_p2_q  <= exp_p2_d;
      frac_p2_q <= frac_p2_d;
      inx_p2_q  <= inx_p2_d;
      sign_p2_q <= sign_p1_q;
      tiny_p2_q <= tiny_p1_q;
      nan_p2_q  <= nan_p1_q;
      inf_p2_q  <= inf_p1_q;
      rm_p2_q   <= rm_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_p3_q <= '0;
      ovf_p3_q  <= 1'b0;
      unf_p3_q  <= 1'b0;
      inx_p3_q  <= 1'b0;
    end else if (en3 && vld_p2_q) begin
      data_p3_q <= data_p3_d;
      ovf_p3_q  <= ovf_p3_d;
      unf_p3_q  <= unf_p3_d;
      inx_p3_q  <= inx_p3_d;
    end
  end

  assign out_valid     = vld_p3_q;
  assign out_data      = data_p3_q;
  assign out_overflow  = ovf_p3_q;
  assign out_underflow = unf_p3_q;
  assign out_inexact   = inx_p3_q;

endmodule
